// File: rtl/npc_defs.sv
// rtl/npc_defs.sv - shared NPC core defaults, constants and read-source selection
//
// Purpose : default widths, the hardwired-zero address, the reset-active
//           level and the per-port read-source select used by the register file.
// Ports   : none (package).

package npc_defs;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;

  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR  = '0;
  localparam logic                  RST_ACTIVE = 1'b0;

  // Where a read port takes its value from.
  typedef enum logic [1:0] {
    SRC_ARRAY  = 2'd0,
    SRC_BYPASS = 2'd1,
    SRC_ZERO   = 2'd2
  } src_sel_e;

  // Zero entry has priority over forwarding: a write to entry 0 is dropped,
  // so forwarding its data would return a value the array never holds.
  function automatic src_sel_e src_select(input logic is_zero, input logic is_fwd);
    if (is_zero) return SRC_ZERO;
    if (is_fwd)  return SRC_BYPASS;
    return SRC_ARRAY;
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// rtl/regfile_rd_port.sv - one register-file read port: source select plus optional output register
//
// Purpose : picks zero / forwarded write data / array data for one read port,
//           then either drives it straight out (RD_REG=0) or registers it
//           on ren (RD_REG=1, one-cycle latency).
// Ports   : clk, rst (async, active-low)
//           ren               - read enable (registered mode only)
//           raddr             - read address
//           wen/waddr/wdata   - write port of the same cycle, for forwarding
//           mem_rdata         - array contents at raddr
//           rdata, rvalid     - read result and its valid flag

module regfile_rd_port #(
  parameter int ADDR_WIDTH = npc_defs::ADDR_WIDTH,
  parameter int DATA_WIDTH = npc_defs::DATA_WIDTH,
  parameter int ZERO_REG   = 1,
  parameter int RD_REG     = 0,
  parameter int BYPASS     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ren,
  input  logic [ADDR_WIDTH-1:0] raddr,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid
);

  import npc_defs::*;

  src_sel_e              sel;
  logic [DATA_WIDTH-1:0] src_val;

  always_comb begin
    sel = src_select((ZERO_REG != 0) && (raddr == ADDR_WIDTH'(ZERO_ADDR)),
                     (BYPASS != 0) && wen && (waddr == raddr));
    src_val = mem_rdata;
    case (sel)
      SRC_ZERO:   src_val = '0;
      SRC_BYPASS: src_val = wdata;
      default:    src_val = mem_rdata;
    endcase
  end

  generate
    if (RD_REG != 0) begin : g_reg
      always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
          rdata  <= '0;
          rvalid <= 1'b0;
        end else if (ren) begin
          rdata  <= src_val;
          rvalid <= 1'b1;
        end else begin
          rvalid <= 1'b0;
        end
      end
    end else begin : g_comb
      // Clock, reset and ren have no role on a combinational port.
      logic unused_ok;
      assign unused_ok = &{1'b0, clk, rst, ren};
      assign rdata     = src_val;
      assign rvalid    = 1'b1;
    end
  endgenerate

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with pending-write scoreboard
//
// Purpose : one write port, NR_RD read ports, optional zero entry, optional
//           write-to-read forwarding, combinational or registered reads, and
//           a per-entry busy bit for RAW hazard detection at decode.
// Ports   : clk, rst (async, active-low)
//           wen, waddr, wdata    - write port (from writeback)
//           ren, raddr           - per-port read enable / packed read addresses
//           rdata, rvalid        - packed read data / per-port valid
//           busy_set, busy_addr  - mark an entry as pending a write (from decode)
//           rbusy                - busy bit of each read port's entry

module regfile_mp #(
  parameter int ADDR_WIDTH = npc_defs::ADDR_WIDTH,
  parameter int DATA_WIDTH = npc_defs::DATA_WIDTH,
  parameter int NR_RD      = 2,
  parameter int ZERO_REG   = 1,
  parameter int RD_REG     = 0,
  parameter int BYPASS     = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wen,
  input  logic [ADDR_WIDTH-1:0]       waddr,
  input  logic [DATA_WIDTH-1:0]       wdata,
  input  logic [NR_RD-1:0]            ren,
  input  logic [NR_RD*ADDR_WIDTH-1:0] raddr,
  output logic [NR_RD*DATA_WIDTH-1:0] rdata,
  output logic [NR_RD-1:0]            rvalid,
  input  logic                        busy_set,
  input  logic [ADDR_WIDTH-1:0]       busy_addr,
  output logic [NR_RD-1:0]            rbusy
);

  import npc_defs::*;

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]      busy;
  logic [DEPTH-1:0]      busy_nxt;
  logic                  wr_drop;

  assign wr_drop = (ZERO_REG != 0) && (waddr == ADDR_WIDTH'(ZERO_ADDR));

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wen && !wr_drop) begin
      mem[waddr] <= wdata;
    end
  end

  // Set is applied after clear so that a new producer issued in the same
  // cycle as the old one's writeback keeps the entry pending.
  always_comb begin
    busy_nxt = busy;
    if (wen)             busy_nxt[waddr]     = 1'b0;
    if (busy_set)        busy_nxt[busy_addr] = 1'b1;
    if (ZERO_REG != 0)   busy_nxt[0]         = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  generate
    for (genvar g = 0; g < NR_RD; g++) begin : g_rd
      logic [ADDR_WIDTH-1:0] ra;
      logic [DATA_WIDTH-1:0] mem_rdata;

      assign ra        = raddr[g*ADDR_WIDTH +: ADDR_WIDTH];
      assign mem_rdata = mem[ra];
      // Registered state before this edge; no clear-forwarding from wen.
      assign rbusy[g]  = busy[ra];

      regfile_rd_port #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .ZERO_REG   (ZERO_REG),
        .RD_REG     (RD_REG),
        .BYPASS     (BYPASS)
      ) u_rd_port (
        .clk       (clk),
        .rst       (rst),
        .ren       (ren[g]),
        .raddr     (ra),
        .wen       (wen),
        .waddr     (waddr),
        .wdata     (wdata),
        .mem_rdata (mem_rdata),
        .rdata     (rdata[g*DATA_WIDTH +: DATA_WIDTH]),
        .rvalid    (rvalid[g])
      );
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - self-checking bench for regfile_mp in three configurations

module tb_regfile_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        wen;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        busy_set;
  logic [4:0]  busy_addr;

  // u_a: defaults (2 ports, combinational, bypass on)
  logic [1:0]   ren_a;
  logic [4:0]   ra_a [2];
  logic [9:0]   raddr_a;
  logic [63:0]  rdata_a;
  logic [1:0]   rvalid_a, rbusy_a;
  assign raddr_a = {ra_a[1], ra_a[0]};

  // u_b: 4 ports, combinational, bypass off
  logic [3:0]   ren_b;
  logic [4:0]   ra_b [4];
  logic [19:0]  raddr_b;
  logic [127:0] rdata_b;
  logic [3:0]   rvalid_b, rbusy_b;
  assign raddr_b = {ra_b[3], ra_b[2], ra_b[1], ra_b[0]};

  // u_c: 2 ports, registered, bypass on
  logic [1:0]   ren_c;
  logic [4:0]   ra_c [2];
  logic [9:0]   raddr_c;
  logic [63:0]  rdata_c;
  logic [1:0]   rvalid_c, rbusy_c;
  assign raddr_c = {ra_c[1], ra_c[0]};

  regfile_mp #(.NR_RD(2), .ZERO_REG(1), .RD_REG(0), .BYPASS(1)) u_a (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
    .ren(ren_a), .raddr(raddr_a), .rdata(rdata_a), .rvalid(rvalid_a),
    .busy_set(busy_set), .busy_addr(busy_addr), .rbusy(rbusy_a));

  regfile_mp #(.NR_RD(4), .ZERO_REG(1), .RD_REG(0), .BYPASS(0)) u_b (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
    .ren(ren_b), .raddr(raddr_b), .rdata(rdata_b), .rvalid(rvalid_b),
    .busy_set(busy_set), .busy_addr(busy_addr), .rbusy(rbusy_b));

  regfile_mp #(.NR_RD(2), .ZERO_REG(1), .RD_REG(1), .BYPASS(1)) u_c (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
    .ren(ren_c), .raddr(raddr_c), .rdata(rdata_c), .rvalid(rvalid_c),
    .busy_set(busy_set), .busy_addr(busy_addr), .rbusy(rbusy_c));

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q [$];

  typedef struct {
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] exp0;   // u_a port 0 (bypass)
    logic [31:0] exp1;   // u_a port 1 (bypass)
    logic [31:0] expb0;  // u_b port 0 at ra0 (no bypass)
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] d);
    exp_q.push_back(d);
  endtask

  task automatic pop_check(input string name, input logic [31:0] act);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: got %0h expected <empty scoreboard>", name, act);
    end else begin
      e = exp_q.pop_front();
      check(name, {96'd0, act}, {96'd0, e});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 5'd3, 32'h12345678, 5'd3, 5'd0, 32'h12345678, 32'h0,        32'h0};
    vecs[1] = '{1'b1, 5'd0, 32'hFFFFFFFF, 5'd3, 5'd0, 32'h12345678, 32'h0,        32'h12345678};
    vecs[2] = '{1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd7, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0};
    vecs[3] = '{1'b0, 5'd0, 32'h0,        5'd7, 5'd3, 32'hA5A5A5A5, 32'h12345678, 32'hA5A5A5A5};
    vecs[4] = '{1'b1, 5'd1, 32'h11,       5'd1, 5'd0, 32'h11,       32'h0,        32'h0};
    vecs[5] = '{1'b1, 5'd2, 32'h22,       5'd2, 5'd1, 32'h22,       32'h11,       32'h0};
    vecs[6] = '{1'b1, 5'd4, 32'h44,       5'd4, 5'd2, 32'h44,       32'h22,       32'h0};
    vecs[7] = '{1'b0, 5'd0, 32'h0,        5'd31, 5'd4, 32'h0,       32'h44,       32'h0};

    rst = 1'b0; wen = 1'b0; waddr = '0; wdata = '0; busy_set = 1'b0; busy_addr = '0;
    ren_a = '0; ren_b = '0; ren_c = '0;
    for (int i = 0; i < 2; i++) begin ra_a[i] = '0; ra_c[i] = '0; end
    for (int i = 0; i < 4; i++) ra_b[i] = '0;

    // Reset held three cycles.
    repeat (3) tick();
    check("rst_rvalid_c", rvalid_c, 2'b00);
    check("rst_rdata_c", rdata_c, 64'd0);
    rst = 1'b1;

    // Every entry reads zero and not busy after reset.
    for (int i = 0; i < 32; i++) begin
      ra_a[0] = 5'(i);
      ra_a[1] = 5'(31 - i);
      #1;
      check($sformatf("rst_rd0_e%0d", i), rdata_a[31:0], 32'd0);
      check($sformatf("rst_rd1_e%0d", 31 - i), rdata_a[63:32], 32'd0);
      check($sformatf("rst_busy_e%0d", i), rbusy_a, 2'b00);
    end
    check("rvalid_a_const", rvalid_a, 2'b11);
    check("rvalid_b_const", rvalid_b, 4'hF);

    // Reset in the middle of a write to entry 5 that already holds data.
    tick();
    wen = 1'b1; waddr = 5'd5; wdata = 32'h55; busy_set = 1'b1; busy_addr = 5'd5;
    ra_a[0] = 5'd5;
    tick();
    busy_set = 1'b0;
    wdata = 32'hDEADBEEF;
    check("pre_rst_busy5", rbusy_a[0], 1'b1);
    check("pre_rst_b_e5", rdata_b[31:0], 32'd0);
    ra_b[0] = 5'd5;
    #1;
    check("pre_rst_b_e5_old", rdata_b[31:0], 32'h55);
    #1;
    rst = 1'b0;
    #1;
    check("async_rst_busy5", rbusy_a[0], 1'b0);
    check("async_rst_b_e5", rdata_b[31:0], 32'd0);
    @(posedge clk);
    #1;
    wen = 1'b0; rst = 1'b1;
    #1;
    check("post_rst_e5", rdata_a[31:0], 32'd0);
    tick();

    // Table: write/read, zero entry, bypass on (u_a) and off (u_b).
    for (int i = 0; i < 8; i++) begin
      wen = vecs[i].wen; waddr = vecs[i].waddr; wdata = vecs[i].wdata;
      ra_a[0] = vecs[i].ra0; ra_a[1] = vecs[i].ra1; ra_b[0] = vecs[i].ra0;
      push_exp(vecs[i].exp0);
      push_exp(vecs[i].exp1);
      push_exp(vecs[i].expb0);
      #1;
      pop_check($sformatf("vec%0d_a0", i), rdata_a[31:0]);
      pop_check($sformatf("vec%0d_a1", i), rdata_a[63:32]);
      pop_check($sformatf("vec%0d_b0", i), rdata_b[31:0]);
      tick();
    end
    wen = 1'b0;

    // Multi-port: all on one address, then distinct addresses.
    for (int p = 0; p < 4; p++) ra_b[p] = 5'd3;
    for (int p = 0; p < 4; p++) push_exp(32'h12345678);
    #1;
    for (int p = 0; p < 4; p++) pop_check($sformatf("mp_same_p%0d", p), rdata_b[p*32 +: 32]);
    ra_b[0] = 5'd1; ra_b[1] = 5'd2; ra_b[2] = 5'd4; ra_b[3] = 5'd3;
    push_exp(32'h11); push_exp(32'h22); push_exp(32'h44); push_exp(32'h12345678);
    #1;
    for (int p = 0; p < 4; p++) pop_check($sformatf("mp_dist_p%0d", p), rdata_b[p*32 +: 32]);

    // Registered read: one-cycle latency, hold, and bypass from the ren cycle.
    ren_c = 2'b01; ra_c[0] = 5'd3; ra_c[1] = 5'd0;
    push_exp(32'h12345678);
    tick();
    check("rreg_rvalid", rvalid_c, 2'b01);
    pop_check("rreg_rdata0", rdata_c[31:0]);
    check("rreg_rdata1_untouched", rdata_c[63:32], 32'd0);
    ren_c = 2'b00;
    tick();
    check("rreg_rvalid_drop", rvalid_c, 2'b00);
    check("rreg_rdata0_hold", rdata_c[31:0], 32'h12345678);
    wen = 1'b1; waddr = 5'd10; wdata = 32'hCAFEF00D;
    ren_c = 2'b10; ra_c[1] = 5'd10;
    push_exp(32'hCAFEF00D);
    tick();
    wen = 1'b0; ren_c = 2'b00;
    check("rreg_byp_rvalid", rvalid_c, 2'b10);
    pop_check("rreg_byp_rdata1", rdata_c[63:32]);
    check("rreg_byp_rdata0_hold", rdata_c[31:0], 32'h12345678);
    ren_c = 2'b11; ra_c[0] = 5'd7; ra_c[1] = 5'd7;
    push_exp(32'hA5A5A5A5); push_exp(32'hA5A5A5A5);
    tick();
    ren_c = 2'b00;
    check("rreg_both_rvalid", rvalid_c, 2'b11);
    pop_check("rreg_both_p0", rdata_c[31:0]);
    pop_check("rreg_both_p1", rdata_c[63:32]);

    // Scoreboard.
    ra_a[0] = 5'd9;
    busy_set = 1'b1; busy_addr = 5'd9;
    #1;
    check("sb_set_pre", rbusy_a[0], 1'b0);
    tick();
    busy_set = 1'b0;
    #1;
    check("sb_set_post", rbusy_a[0], 1'b1);
    wen = 1'b1; waddr = 5'd9; wdata = 32'h99;
    #1;
    check("sb_clr_pre", rbusy_a[0], 1'b1);
    tick();
    wen = 1'b0;
    #1;
    check("sb_clr_post", rbusy_a[0], 1'b0);
    busy_set = 1'b1; busy_addr = 5'd9; wen = 1'b1; waddr = 5'd9; wdata = 32'h98;
    tick();
    busy_set = 1'b0; wen = 1'b0;
    #1;
    check("sb_set_wins", rbusy_a[0], 1'b1);
    ra_a[1] = 5'd0;
    busy_set = 1'b1; busy_addr = 5'd0;
    tick();
    busy_set = 1'b0;
    #1;
    check("sb_zero_never_busy", rbusy_a[1], 1'b0);
    check("sb_e9_still_busy", rbusy_a[0], 1'b1);
    check("sb_e9_data", rdata_a[31:0], 32'h98);

    check("scoreboard_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
